int_issue_queue: RTL and testbench

Integer issue queue sitting between dispatch and the ALU/LSU execute ports. Accepts at most one renamed, ROB-indexed instruction per cycle from dispatch. Holds it until both physical sources are ready, tracking readiness through writeback wakeup broadcasts. Issues the oldest ready entry by ROB age, and kills entries younger than a redirect flush.

---
 rtl/int_issue_queue.sv | 149 ++++++++++++++
 tb/tb_int_issue_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - integer issue queue: wakeup tracking, oldest-ready select by ROB age, flush kill
module int_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 128,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [PREG_W-1:0]     enq_prs1,
  input  logic [PREG_W-1:0]     enq_prs2,
  input  logic                  enq_src1_is_reg,
  input  logic                  enq_src2_is_reg,
  input  logic                  enq_src1_ready,
  input  logic                  enq_src2_ready,
  input  logic                  enq_robidx_flag,
  input  logic [ROB_W-1:0]      enq_robidx,
  input  logic [PAYLOAD_W-1:0]  enq_payload,
  input  logic [1:0]            wb_valid,
  input  logic [2*PREG_W-1:0]   wb_prd,
  output logic                  iss_valid,
  input  logic                  iss_ready,
  output logic [PREG_W-1:0]     iss_prs1,
  output logic [PREG_W-1:0]     iss_prs2,
  output logic                  iss_robidx_flag,
  output logic [ROB_W-1:0]      iss_robidx,
  output logic [PAYLOAD_W-1:0]  iss_payload,
  input  logic                  flush_valid,
  input  logic                  flush_robidx_flag,
  input  logic [ROB_W-1:0]      flush_robidx,
  output logic [CNT_W-1:0]      count
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     rdy1;
  logic [DEPTH-1:0]     rdy2;
  logic [PREG_W-1:0]    prs1    [DEPTH];
  logic [PREG_W-1:0]    prs2    [DEPTH];
  logic                 rflag   [DEPTH];
  logic [ROB_W-1:0]     ridx    [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];

  logic [PREG_W-1:0] wb_prd0;
  logic [PREG_W-1:0] wb_prd1;
  logic [DEPTH-1:0]  hit1;
  logic [DEPTH-1:0]  hit2;
  logic [DEPTH-1:0]  kill;
  logic              enq_hit1;
  logic              enq_hit2;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  surv_cnt;
  logic              enq_fire;
  logic              iss_fire;

  // Age across ROB wrap: same flag compares indices directly, differing flag inverts.
  function automatic logic is_older(input logic af, input logic [ROB_W-1:0] ai,
                                    input logic bf, input logic [ROB_W-1:0] bi);
    return (af == bf) ? (ai < bi) : (ai > bi);
  endfunction

  assign wb_prd0 = wb_prd[0 +: PREG_W];
  assign wb_prd1 = wb_prd[PREG_W +: PREG_W];

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    kill = '0;
    surv_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = (wb_valid[0] && (wb_prd0 == prs1[i])) || (wb_valid[1] && (wb_prd1 == prs1[i]));
      hit2[i] = (wb_valid[0] && (wb_prd0 == prs2[i])) || (wb_valid[1] && (wb_prd1 == prs2[i]));
      kill[i] = valid[i] && is_older(flush_robidx_flag, flush_robidx, rflag[i], ridx[i]);
      surv_cnt = surv_cnt + CNT_W'(valid[i] && !kill[i]);
    end
    enq_hit1 = (wb_valid[0] && (wb_prd0 == enq_prs1)) || (wb_valid[1] && (wb_prd1 == enq_prs1));
    enq_hit2 = (wb_valid[0] && (wb_prd0 == enq_prs2)) || (wb_valid[1] && (wb_prd1 == enq_prs2));
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && rdy1[i] && rdy2[i]) begin
        if (!sel_found || is_older(rflag[i], ridx[i], rflag[sel_idx], ridx[sel_idx])) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign enq_ready       = (count < CNT_W'(DEPTH));
  assign iss_valid       = sel_found && !flush_valid;
  assign iss_prs1        = prs1[sel_idx];
  assign iss_prs2        = prs2[sel_idx];
  assign iss_robidx_flag = rflag[sel_idx];
  assign iss_robidx      = ridx[sel_idx];
  assign iss_payload     = payload[sel_idx];
  // count tracks popcount, so enq_ready implies free_found; the extra term keeps the write safe.
  assign enq_fire        = enq_valid && enq_ready && free_found && !flush_valid;
  assign iss_fire        = iss_valid && iss_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && hit1[i]) rdy1[i] <= 1'b1;
        if (valid[i] && hit2[i]) rdy2[i] <= 1'b1;
      end
      if (flush_valid) begin
        valid <= valid & ~kill;
        count <= surv_cnt;
      end else begin
        if (iss_fire) valid[sel_idx] <= 1'b0;
        if (enq_fire) begin
          valid[free_idx]   <= 1'b1;
          rdy1[free_idx]    <= !enq_src1_is_reg || enq_src1_ready || enq_hit1;
          rdy2[free_idx]    <= !enq_src2_is_reg || enq_src2_ready || enq_hit2;
          prs1[free_idx]    <= enq_prs1;
          prs2[free_idx]    <= enq_prs2;
          rflag[free_idx]   <= enq_robidx_flag;
          ridx[free_idx]    <= enq_robidx;
          payload[free_idx] <= enq_payload;
        end
        count <= count + CNT_W'(enq_fire) - CNT_W'(iss_fire);
      end
    end
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - directed self-checking bench for int_issue_queue
module tb_int_issue_queue;
  logic         clock = 1'b0;
  logic         reset;
  logic         enq_valid;
  logic         enq_ready;
  logic [5:0]   enq_prs1, enq_prs2;
  logic         enq_src1_is_reg, enq_src2_is_reg;
  logic         enq_src1_ready, enq_src2_ready;
  logic         enq_robidx_flag;
  logic [5:0]   enq_robidx;
  logic [127:0] enq_payload;
  logic [1:0]   wb_valid;
  logic [11:0]  wb_prd;
  logic         iss_valid;
  logic         iss_ready;
  logic [5:0]   iss_prs1, iss_prs2;
  logic         iss_robidx_flag;
  logic [5:0]   iss_robidx;
  logic [127:0] iss_payload;
  logic         flush_valid;
  logic         flush_robidx_flag;
  logic [5:0]   flush_robidx;
  logic [3:0]   count;

  int n_vec = 0;
  int n_bad = 0;

  int_issue_queue dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
    .enq_src1_ready(enq_src1_ready), .enq_src2_ready(enq_src2_ready),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx), .enq_payload(enq_payload),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2),
    .iss_robidx_flag(iss_robidx_flag), .iss_robidx(iss_robidx), .iss_payload(iss_payload),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pay(input logic f, input logic [5:0] idx);
    return {8'h5A, 104'd0, 8'(idx), 7'd0, f};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic f, input logic [5:0] idx,
                     input logic s1r, input logic s1y, input logic [5:0] p1,
                     input logic s2r, input logic s2y, input logic [5:0] p2);
    enq_valid       = 1'b1;
    enq_robidx_flag = f;
    enq_robidx      = idx;
    enq_src1_is_reg = s1r;
    enq_src1_ready  = s1y;
    enq_prs1        = p1;
    enq_src2_is_reg = s2r;
    enq_src2_ready  = s2y;
    enq_prs2        = p2;
    enq_payload     = pay(f, idx);
    tick();
    enq_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; enq_valid = 0; enq_prs1 = 0; enq_prs2 = 0;
    enq_src1_is_reg = 0; enq_src2_is_reg = 0; enq_src1_ready = 0; enq_src2_ready = 0;
    enq_robidx_flag = 0; enq_robidx = 0; enq_payload = 0;
    wb_valid = 0; wb_prd = 0; iss_ready = 0;
    flush_valid = 0; flush_robidx_flag = 0; flush_robidx = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_iss_valid", iss_valid, 0);

    // basic enqueue/issue of immediate-only instruction
    enq(0, 6'd3, 0, 0, 6'd0, 0, 0, 6'd0);
    check("basic_count", count, 1);
    check("basic_iss_valid", iss_valid, 1);
    check("basic_iss_robidx", iss_robidx, 3);
    check("basic_payload", iss_payload, pay(0, 6'd3));
    iss_ready = 1; tick(); iss_ready = 0; #1;
    check("basic_drain_count", count, 0);
    check("basic_drain_iss_valid", iss_valid, 0);

    // wakeup through port 1
    enq(0, 6'd10, 1, 0, 6'd12, 0, 0, 6'd0);
    repeat (5) tick();
    check("wake_wait_iss_valid", iss_valid, 0);
    check("wake_wait_count", count, 1);
    wb_valid = 2'b10; wb_prd = {6'd12, 6'd0}; #1;
    check("wake_same_cycle", iss_valid, 0);
    tick(); wb_valid = 0; wb_prd = 0; #1;
    check("wake_iss_valid", iss_valid, 1);
    check("wake_iss_prs1", iss_prs1, 12);
    check("wake_iss_robidx", iss_robidx, 10);
    iss_ready = 1; tick(); iss_ready = 0; #1;
    check("wake_drain", count, 0);

    // ROB wrap ordering, enqueued out of age order
    enq(0, 6'd63, 0, 0, 6'd0, 0, 0, 6'd0);
    enq(1, 6'd1,  0, 0, 6'd0, 0, 0, 6'd0);
    enq(0, 6'd62, 0, 0, 6'd0, 0, 0, 6'd0);
    check("wrap_count", count, 3);
    check("wrap_first", {iss_valid, iss_robidx_flag, iss_robidx}, {1'b1, 1'b0, 6'd62});
    iss_ready = 1; tick();
    check("wrap_second", {iss_valid, iss_robidx_flag, iss_robidx}, {1'b1, 1'b0, 6'd63});
    tick();
    check("wrap_third", {iss_valid, iss_robidx_flag, iss_robidx}, {1'b1, 1'b1, 6'd1});
    check("wrap_third_payload", iss_payload, pay(1, 6'd1));
    tick(); iss_ready = 0; #1;
    check("wrap_drain", count, 0);

    // fill with unready entries, then issue while full
    for (int i = 0; i < 8; i++) enq(0, 6'(20 + i), 1, 0, 6'(30 + i), 0, 0, 6'd0);
    check("full_count", count, 8);
    check("full_enq_ready", enq_ready, 0);
    check("full_iss_valid", iss_valid, 0);
    wb_valid = 2'b01; wb_prd = {6'd0, 6'd33}; tick(); wb_valid = 0; wb_prd = 0; #1;
    check("full_wake_robidx", {iss_valid, iss_robidx}, {1'b1, 6'd23});
    iss_ready = 1; enq_valid = 1; enq_robidx = 6'd40; enq_src1_is_reg = 0; enq_src2_is_reg = 0; #1;
    check("full_issue_enq_ready", enq_ready, 0);
    tick(); iss_ready = 0; enq_valid = 0; #1;
    check("full_after_count", count, 7);
    check("full_after_enq_ready", enq_ready, 1);
    check("full_after_iss_valid", iss_valid, 0);
    flush_valid = 1; flush_robidx = 6'd19; tick(); flush_valid = 0; #1;
    check("flush_all_count", count, 0);

    // flush keeps the equal and older entries; concurrent enqueue dropped
    for (int i = 4; i < 8; i++) enq(0, 6'(i), 0, 0, 6'd0, 0, 0, 6'd0);
    check("flush_pre_count", count, 4);
    flush_valid = 1; flush_robidx = 6'd5;
    enq_valid = 1; enq_robidx = 6'd2; enq_src1_is_reg = 0; enq_src2_is_reg = 0; iss_ready = 1; #1;
    check("flush_iss_valid", iss_valid, 0);
    tick(); flush_valid = 0; enq_valid = 0; iss_ready = 0; #1;
    check("flush_count", count, 2);
    check("flush_oldest", {iss_valid, iss_robidx}, {1'b1, 6'd4});
    iss_ready = 1; tick();
    check("flush_next", {iss_valid, iss_robidx}, {1'b1, 6'd5});
    tick(); iss_ready = 0; #1;
    check("flush_drain", {count, iss_valid}, {4'd0, 1'b0});

    // same-cycle wakeup bypass into enqueue
    wb_valid = 2'b01; wb_prd = {6'd0, 6'd20};
    enq(0, 6'd9, 0, 0, 6'd0, 1, 0, 6'd20);
    wb_valid = 0; wb_prd = 0; #1;
    check("bypass_iss_valid", iss_valid, 1);
    check("bypass_iss_prs2", iss_prs2, 20);

    // mid-operation reset discards entries
    enq(0, 6'd11, 1, 0, 6'd40, 0, 0, 6'd0);
    check("prereset_count", count, 2);
    reset = 1; iss_ready = 1; enq_valid = 1; tick(); reset = 0; iss_ready = 0; enq_valid = 0; #1;
    check("midreset_count", count, 0);
    check("midreset_iss_valid", iss_valid, 0);
    check("midreset_enq_ready", enq_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
